// File: rtl/gcd_pkg.sv
// Shared types for the GCD scheduler: A/B register update codes and FSM states.
package gcd_pkg;

  typedef enum logic [1:0] {
    A_SUB    = 2'b00,
    A_LOAD   = 2'b01,
    A_FROM_B = 2'b10,
    A_HOLD   = 2'b11
  } a_op_e;

  typedef enum logic [1:0] {
    B_LOAD   = 2'b00,
    B_FROM_A = 2'b01,
    B_HOLD   = 2'b10
  } b_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping; the pointer register itself lives in the parent.
module gcd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IdW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IdW-1:0]     grant_idx,
  output logic               any_req
);

  logic [IdW:0] idx_s;

  // Scan farthest-to-nearest so the last hit, i.e. the nearest to ptr, wins.
  always_comb begin
    grant_oh  = {NUM_REQ{1'b0}};
    grant_idx = {IdW{1'b0}};
    any_req   = 1'b0;
    idx_s     = {(IdW+1){1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_s = {1'b0, ptr} + (IdW+1)'(i);
      if (idx_s >= (IdW+1)'(NUM_REQ)) begin
        idx_s = idx_s - (IdW+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (req[idx_s[IdW-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = idx_s[IdW-1:0];
      end else begin
        any_req   = any_req;
      end
    end
    grant_oh[grant_idx] = any_req;
  end

endmodule

// File: rtl/gcd_sched.sv
// Shares one subtract-and-swap GCD engine between NUM_REQ requesters.
// Optional: GCD_SCHED_ITER_CNT_EN adds rsp_iter_o, the CALC cycle count per job.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter  int BusSize = 8,
  parameter  int NUM_REQ = 4,
  localparam int IdW     = $clog2(NUM_REQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*BusSize-1:0] req_a_i,
  input  logic [NUM_REQ*BusSize-1:0] req_b_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [BusSize-1:0]         rsp_gcd_o,
  output logic [IdW-1:0]             rsp_id_o,
  output logic                       busy_o
`ifdef GCD_SCHED_ITER_CNT_EN
  ,
  output logic [BusSize:0]           rsp_iter_o
`endif
);

  state_e               state_r, state_nxt_s;
  a_op_e                a_op_s;
  b_op_e                b_op_s;
  logic [BusSize-1:0]   a_r, b_r, rsp_gcd_r, result_s, a_in_s, b_in_s;
  logic [IdW-1:0]       id_r, rr_r, rr_nxt_s, grant_idx_s;
  logic [NUM_REQ-1:0]   grant_oh_s, req_ready_s;
  logic                 any_req_s, accept_s, done_s, rsp_valid_r, busy_r;

  gcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IdW(IdW)) u_arb (
    .req       (req_valid_i),
    .ptr       (rr_r),
    .grant_oh  (grant_oh_s),
    .grant_idx (grant_idx_s),
    .any_req   (any_req_s)
  );

  assign a_in_s   = req_a_i[grant_idx_s*BusSize +: BusSize];
  assign b_in_s   = req_b_i[grant_idx_s*BusSize +: BusSize];
  assign rr_nxt_s = (grant_idx_s == IdW'(NUM_REQ - 1)) ? {IdW{1'b0}} : grant_idx_s + IdW'(1);

  // Next state, operand op codes and the combinational accept strobe.
  always_comb begin
    state_nxt_s = state_r;
    a_op_s      = A_HOLD;
    b_op_s      = B_HOLD;
    req_ready_s = {NUM_REQ{1'b0}};
    result_s    = rsp_gcd_r;
    accept_s    = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // Gated by rst_ni so no requester sees a grant while reset is held.
        if (any_req_s && rst_ni) begin
          req_ready_s = grant_oh_s;
          accept_s    = 1'b1;
          a_op_s      = A_LOAD;
          b_op_s      = B_LOAD;
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (a_r == {BusSize{1'b0}}) begin
          result_s = b_r;
          done_s   = 1'b1;
        end else if (b_r == {BusSize{1'b0}} || a_r == b_r) begin
          result_s = a_r;
          done_s   = 1'b1;
        end else if (a_r < b_r) begin
          a_op_s = A_FROM_B;
          b_op_s = B_FROM_A;
        end else begin
          a_op_s = A_SUB;
        end
        state_nxt_s = done_s ? RESP : CALC;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand, id/pointer and response registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      a_r         <= {BusSize{1'b0}};
      b_r         <= {BusSize{1'b0}};
      id_r        <= {IdW{1'b0}};
      rr_r        <= {IdW{1'b0}};
      rsp_gcd_r   <= {BusSize{1'b0}};
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rsp_valid_r <= (state_nxt_s == RESP);
      busy_r      <= (state_nxt_s != IDLE);
      case (a_op_s)
        A_SUB:    a_r <= a_r - b_r;
        A_LOAD:   a_r <= a_in_s;
        A_FROM_B: a_r <= b_r;
        A_HOLD:   a_r <= a_r;
        default:  a_r <= a_r;
      endcase
      case (b_op_s)
        B_LOAD:   b_r <= b_in_s;
        B_FROM_A: b_r <= a_r;
        B_HOLD:   b_r <= b_r;
        default:  b_r <= b_r;
      endcase
      if (accept_s) begin
        id_r <= grant_idx_s;
        rr_r <= rr_nxt_s;
      end else begin
        id_r <= id_r;
        rr_r <= rr_r;
      end
      if (done_s) begin
        rsp_gcd_r <= result_s;
      end else begin
        rsp_gcd_r <= rsp_gcd_r;
      end
    end
  end

  assign req_ready_o = req_ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_gcd_o   = rsp_gcd_r;
  assign rsp_id_o    = id_r;
  assign busy_o      = busy_r;

`ifdef GCD_SCHED_ITER_CNT_EN
  logic [BusSize:0] iter_r;

  // Saturating count of CALC cycles; frozen outside CALC so it holds during RESP.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      iter_r <= {(BusSize+1){1'b0}};
    end else if (accept_s) begin
      iter_r <= {(BusSize+1){1'b0}};
    end else if (state_r == CALC && iter_r != {(BusSize+1){1'b1}}) begin
      iter_r <= iter_r + (BusSize+1)'(1);
    end else begin
      iter_r <= iter_r;
    end
  end

  assign rsp_iter_o = iter_r;
`endif

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched: directed scenarios plus randomized jobs
// checked against a plain-arithmetic GCD reference.
module tb_gcd_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready, busy;
  logic [7:0]  rsp_gcd;
  logic [1:0]  rsp_id;
`ifdef GCD_SCHED_ITER_CNT_EN
  logic [8:0]  rsp_iter;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  gcd_sched #(.BusSize(8), .NUM_REQ(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_gcd_o   (rsp_gcd),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy)
`ifdef GCD_SCHED_ITER_CNT_EN
    ,
    .rsp_iter_o  (rsp_iter)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Euclid by remainder: a different route to the same answer.
  function automatic logic [7:0] ref_gcd(input int a, input int b);
    int t;
    if (a == 0) return b[7:0];
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a[7:0];
  endfunction

  // Number of decision cycles the subtract-and-swap rules take for (a,b).
  function automatic int ref_calc(input int a, input int b);
    int n, t;
    n = 0;
    forever begin
      n++;
      if (a == 0 || b == 0 || a == b) return n;
      if (a < b) begin
        t = a; a = b; b = t;
      end else begin
        a = a - b;
      end
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 600) begin
      tick();
      cyc++;
    end
  endtask

  // Run one job on requester r and check grant, latency, result and handshake.
  task automatic do_job(input int r, input logic [7:0] a, input logic [7:0] b);
    int          cnt, exp_n;
    logic [7:0]  exp_g;
    logic [3:0]  exp_rdy;
    exp_g   = ref_gcd(int'(a), int'(b));
    exp_n   = ref_calc(int'(a), int'(b));
    exp_rdy = 4'b0001 << r;
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_valid = 4'b0000;
    req_valid[r] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    cnt = 0;
    while (req_ready !== exp_rdy && cnt < 50) begin
      tick();
      cnt++;
    end
    n_chk++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL grant r=%0d: got %b expected %b", r, req_ready, exp_rdy);
    end
    tick();
    req_valid = 4'b0000;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept: got %b expected 1", busy);
    end
    wait_rsp(cnt);
    n_chk++;
    if (cnt != exp_n) begin
      n_fail++;
      $display("FAIL latency (%0d,%0d): got %0d cycles expected %0d", a, b, cnt, exp_n);
    end
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_gcd !== exp_g || rsp_id !== 2'(r)) begin
      n_fail++;
      $display("FAIL result (%0d,%0d): got v=%b gcd=%0d id=%0d expected v=1 gcd=%0d id=%0d",
               a, b, rsp_valid, rsp_gcd, rsp_id, exp_g, r);
    end
`ifdef GCD_SCHED_ITER_CNT_EN
    n_chk++;
    if (rsp_iter !== 9'(exp_n)) begin
      n_fail++;
      $display("FAIL iter (%0d,%0d): got %0d expected %0d", a, b, rsp_iter, exp_n);
    end
`endif
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_drop: got v=%b busy=%b expected 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = $urandom;
    req_b     = $urandom;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
          rsp_gcd !== 8'd0 || rsp_id !== 2'd0) begin
        n_fail++;
        $display("FAIL reset: got rdy=%b v=%b busy=%b gcd=%0d id=%0d expected all 0",
                 req_ready, rsp_valid, busy, rsp_gcd, rsp_id);
      end
    end
`ifdef GCD_SCHED_ITER_CNT_EN
    n_chk++;
    if (rsp_iter !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_iter: got %0d expected 0", rsp_iter);
    end
`endif
    req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    do_job(0, 8'd12, 8'd8);
  endtask

  task automatic test_equal_zero;
    do_job(1, 8'd5, 8'd5);
    do_job(2, 8'd0, 8'd9);
    do_job(3, 8'd0, 8'd0);
    do_job(0, 8'd7, 8'd0);
  endtask

  task automatic test_round_robin;
    logic [7:0] a_v [4];
    logic [7:0] b_v [4];
    int         cnt, exp_id;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 8'($urandom_range(1, 255));
      b_v[i] = 8'($urandom_range(1, 255));
      req_a[i*8 +: 8] = a_v[i];
      req_b[i*8 +: 8] = b_v[i];
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      cnt = 0;
      while (req_ready === 4'b0000 && cnt < 50) begin
        tick();
        cnt++;
      end
      n_chk++;
      if (req_ready !== (4'b0001 << exp_id)) begin
        n_fail++;
        $display("FAIL rr_grant %0d: got %b expected %b", g, req_ready, 4'b0001 << exp_id);
      end
      tick();
      wait_rsp(cnt);
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) ||
          rsp_gcd !== ref_gcd(int'(a_v[exp_id]), int'(b_v[exp_id]))) begin
        n_fail++;
        $display("FAIL rr_result %0d: got v=%b id=%0d gcd=%0d expected id=%0d gcd=%0d", g,
                 rsp_valid, rsp_id, rsp_gcd, exp_id,
                 ref_gcd(int'(a_v[exp_id]), int'(b_v[exp_id])));
      end
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure;
    logic [7:0] a3, b3, a0, b0;
    int         cnt;
    a3 = 8'($urandom_range(1, 255));
    b3 = 8'($urandom_range(1, 255));
    a0 = 8'($urandom_range(1, 255));
    b0 = 8'($urandom_range(1, 255));
    req_a[31:24] = a3;
    req_b[31:24] = b3;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    #1;
    cnt = 0;
    while (req_ready !== 4'b1000 && cnt < 50) begin
      tick();
      cnt++;
    end
    tick();
    req_a[7:0] = a0;
    req_b[7:0] = b0;
    req_valid  = 4'b0001;
    wait_rsp(cnt);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_gcd !== ref_gcd(int'(a3), int'(b3)) ||
          rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL backpressure cyc %0d: got v=%b gcd=%0d id=%0d rdy=%b expected v=1 gcd=%0d id=3 rdy=0000",
                 i, rsp_valid, rsp_gcd, rsp_id, req_ready, ref_gcd(int'(a3), int'(b3)));
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b busy=%b rdy=%b expected 0/0/0001",
               rsp_valid, busy, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    wait_rsp(cnt);
    n_chk++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_gcd !== ref_gcd(int'(a0), int'(b0))) begin
      n_fail++;
      $display("FAIL bp_next_job: got v=%b id=%0d gcd=%0d expected v=1 id=0 gcd=%0d",
               rsp_valid, rsp_id, rsp_gcd, ref_gcd(int'(a0), int'(b0)));
    end
    tick();
  endtask

  task automatic test_reset_mid_calc;
    int seen;
    req_a[7:0] = 8'd255;
    req_b[7:0] = 8'd1;
    rsp_ready  = 1'b1;
    req_valid  = 4'b0001;
    #1;
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_calc_busy: got busy=%b v=%b expected 1/0", busy, rsp_valid);
    end
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_calc_reset: got busy=%b v=%b rdy=%b expected 0", busy, rsp_valid, req_ready);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL dropped_job: got %0d active cycles expected 0", seen);
    end
    do_job(0, 8'd48, 8'd18);
  endtask

  task automatic test_random;
    int          r;
    logic [7:0]  a, b, k;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      k = 8'($urandom_range(1, 12));
      a = 8'(int'(k) * $urandom_range(0, 255 / int'(k)));
      b = 8'(int'(k) * $urandom_range(0, 255 / int'(k)));
      do_job(r, a, b);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = 32'd0;
    req_b     = 32'd0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_equal_zero();
    test_round_robin();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
